// File: rtl/nbit_serial_add.sv
// Bit-serial N-bit adder: one full-adder slice, registered carry, LSB first.
// Computes sum = a + b + c_in over N cycles, using a start/busy/done handshake.
module nbit_serial_add #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   a_sh, b_sh, res, res_nx;
  logic [CW-1:0]  cnt;
  logic           cy, s, carry, last;

  // Full-adder slice on the current LSBs.
  assign s      = a_sh[0] ^ b_sh[0] ^ cy;
  assign carry  = (a_sh[0] & b_sh[0]) | (a_sh[0] & cy) | (b_sh[0] & cy);
  assign last   = (cnt == CW'(N - 1));
  assign res_nx = N'({s, res} >> 1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (last)  state_nx = IDLE;
      default:         state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            cy   <= c_in;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cy   <= carry;
          res  <= res_nx;
          cnt  <= cnt + 1'b1;
          if (last) begin
            sum   <= res_nx;
            c_out <= carry;
            // cy still holds the carry into bit N-1 on this edge.
            ovf   <= cy ^ carry;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
